// File: rtl/alu_arbiter.sv
// Round-robin arbiter that shares one external combinational ALU between two requesters.
// Define ALU_ARB_MUL_EN to make op 111 (multiply) legal, executed over EXEC + MUL2.
module alu_arbiter #(
  parameter int OVF_CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 req0_valid,
  output logic                 req0_ready,
  input  logic [31:0]          req0_a,
  input  logic [31:0]          req0_b,
  input  logic [2:0]           req0_op,
  input  logic                 req0_unsig,
  input  logic                 req1_valid,
  output logic                 req1_ready,
  input  logic [31:0]          req1_a,
  input  logic [31:0]          req1_b,
  input  logic [2:0]           req1_op,
  input  logic                 req1_unsig,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic                 rsp_id,
  output logic [31:0]          rsp_data,
  output logic                 rsp_ovf,
  output logic                 rsp_err,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_op,
  output logic                 alu_unsig,
  input  logic [31:0]          alu_out,
  input  logic                 alu_overflow,
  output logic [OVF_CNT_W-1:0] ovf_count,
  output logic                 busy
);

  typedef enum logic [1:0] {IDLE, EXEC, MUL2, RESP} state_t;

  state_t      state, state_nxt;
  logic        last_grant;
  logic        grant;
  logic        accept;
  logic        capture;
  logic [2:0]  sel_op;
  logic [31:0] opr_a, opr_b;
  logic [2:0]  opr_op;
  logic        opr_unsig;
  logic [31:0] data_q;
  logic        ovf_q, err_q, id_q;

  function automatic logic op_legal(input logic [2:0] op);
    logic legal;
    case (op)
      3'b011:  legal = 1'b0;
`ifdef ALU_ARB_MUL_EN
      3'b111:  legal = 1'b1;
`else
      3'b111:  legal = 1'b0;
`endif
      default: legal = 1'b1;
    endcase
    return legal;
  endfunction

  // Ready is gated by rst_n so both ready outputs read 0 while reset is held.
  always_comb begin
    grant      = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
    accept     = rst_n && (state == IDLE) && (req0_valid || req1_valid);
    req0_ready = accept && !grant;
    req1_ready = accept && grant;
    sel_op     = grant ? req1_op : req0_op;
  end

  always_comb begin
    state_nxt = state;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) state_nxt = op_legal(sel_op) ? EXEC : RESP;
      end
      EXEC: begin
        state_nxt = RESP;
        capture   = 1'b1;
`ifdef ALU_ARB_MUL_EN
        if (opr_op == 3'b111) begin
          state_nxt = MUL2;
          capture   = 1'b0;
        end
`endif
      end
      MUL2: begin
`ifdef ALU_ARB_MUL_EN
        state_nxt = RESP;
        capture   = 1'b1;
`else
        state_nxt = IDLE;
`endif
      end
      RESP: begin
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      opr_a      <= '0;
      opr_b      <= '0;
      opr_op     <= '0;
      opr_unsig  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        last_grant <= grant;
        opr_a      <= grant ? req1_a : req0_a;
        opr_b      <= grant ? req1_b : req0_b;
        opr_op     <= sel_op;
        opr_unsig  <= grant ? req1_unsig : req0_unsig;
      end
    end
  end

  // Illegal ops get their error response written at accept; legal ones overwrite data/ovf at capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
      err_q  <= 1'b0;
      id_q   <= 1'b0;
    end else if (accept) begin
      data_q <= '0;
      ovf_q  <= 1'b0;
      err_q  <= !op_legal(sel_op);
      id_q   <= grant;
    end else if (capture) begin
      data_q <= alu_out;
      ovf_q  <= alu_overflow;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf_count <= '0;
    end else if ((state == RESP) && rsp_ready && ovf_q && (ovf_count != '1)) begin
      ovf_count <= ovf_count + OVF_CNT_W'(1);
    end
  end

  always_comb begin
    rsp_valid = (state == RESP);
    rsp_id    = id_q;
    rsp_data  = data_q;
    rsp_ovf   = ovf_q;
    rsp_err   = err_q;
    busy      = (state != IDLE);
    alu_a     = (state == IDLE) ? '0 : opr_a;
    alu_b     = (state == IDLE) ? '0 : opr_b;
    alu_op    = (state == IDLE) ? '0 : opr_op;
    alu_unsig = (state == IDLE) ? 1'b0 : opr_unsig;
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: models the external ALU, table-driven vectors plus
// hand-written sequences for stall, reset, round-robin and counter saturation.
module tb_alu_arbiter;

  localparam int OVF_CNT_W = 8;
  localparam logic [OVF_CNT_W-1:0] CNT_MAX = '1;

  typedef struct {
    logic [2:0]  op;
    logic        unsig;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] data;
    logic        ovf;
    logic        err;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    logic        ovf;
    logic        err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req0_valid, req0_ready, req0_unsig;
  logic req1_valid, req1_ready, req1_unsig;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        rsp_valid, rsp_ready, rsp_id, rsp_ovf, rsp_err;
  logic [31:0] rsp_data;
  logic [31:0] alu_a, alu_b, alu_out;
  logic [2:0]  alu_op;
  logic        alu_unsig, alu_overflow;
  logic [OVF_CNT_W-1:0] ovf_count;
  logic        busy;
  logic [32:0] sum33;

  exp_t sb_q[$];
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [OVF_CNT_W-1:0] exp_cnt = '0;

  alu_arbiter #(.OVF_CNT_W(OVF_CNT_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_unsig(req0_unsig),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_unsig(req1_unsig),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .rsp_ovf(rsp_ovf), .rsp_err(rsp_err),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_unsig(alu_unsig),
    .alu_out(alu_out), .alu_overflow(alu_overflow),
    .ovf_count(ovf_count), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference model of the shared combinational ALU.
  always_comb begin
    alu_out      = '0;
    alu_overflow = 1'b0;
    sum33        = '0;
    case (alu_op)
      3'b000: alu_out = alu_a & alu_b;
      3'b001: alu_out = alu_a | alu_b;
      3'b010: begin
        sum33        = {1'b0, alu_a} + {1'b0, alu_b};
        alu_out      = sum33[31:0];
        alu_overflow = alu_unsig ? sum33[32]
                                 : (alu_a[31] == alu_b[31]) && (sum33[31] != alu_a[31]);
      end
      3'b100: begin
        alu_out      = alu_a - alu_b;
        alu_overflow = alu_unsig ? (alu_a < alu_b)
                                 : (alu_a[31] != alu_b[31]) && (alu_out[31] != alu_a[31]);
      end
      3'b101: alu_out = alu_a ^ alu_b;
      3'b110: alu_out = {31'd0, alu_unsig ? (alu_a < alu_b) : ($signed(alu_a) < $signed(alu_b))};
      3'b111: alu_out = alu_a * alu_b;
      default: alu_out = '0;
    endcase
  end

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, req);
    end
  endtask

  task automatic doReset;
    rst_n      = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp_ready  = 1'b0;
    sb_q.delete();
    exp_cnt = '0;
    tick;
    rst_n = 1'b1;
  endtask

  // Drives one request at a negedge and returns at the negedge after its accept edge.
  task automatic applyStimulus(input logic id, input logic [2:0] op, input logic unsig,
                               input logic [31:0] a, input logic [31:0] b,
                               input exp_t e, output bit ok);
    ok = 1'b0;
    if (id == 1'b0) begin
      req0_a = a; req0_b = b; req0_op = op; req0_unsig = unsig; req0_valid = 1'b1;
    end else begin
      req1_a = a; req1_b = b; req1_op = op; req1_unsig = unsig; req1_valid = 1'b1;
    end
    sb_q.push_back(e);
    for (int i = 0; i < 20; i++) begin
      #1;
      if ((id == 1'b0) ? req0_ready : req1_ready) begin
        ok = 1'b1;
        break;
      end
      tick;
    end
    if (!ok) begin
      compare("accept timeout", 32'(0), 32'(1));
      void'(sb_q.pop_back());
    end
    tick;
    if (id == 1'b0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  // Waits for the response, compares it with the scoreboard head, optionally stalls, then handshakes.
  task automatic checkOutput(input string name, input int exp_lat, input int hold);
    int   lat = 1;
    exp_t e;
    while (!rsp_valid && lat < 20) begin
      tick;
      lat++;
    end
    compare({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (!rsp_valid) return;
    if (sb_q.size() == 0) begin
      compare({name, " scoreboard empty"}, 32'(0), 32'(1));
      return;
    end
    e = sb_q.pop_front();
    compare({name, " id"},   32'(rsp_id),  32'(e.id));
    compare({name, " data"}, rsp_data,     e.data);
    compare({name, " ovf"},  32'(rsp_ovf), 32'(e.ovf));
    compare({name, " err"},  32'(rsp_err), 32'(e.err));
    for (int h = 0; h < hold; h++) begin
      tick;
      #1;
      compare({name, " hold valid"}, 32'(rsp_valid), 32'(1));
      compare({name, " hold data"},  rsp_data, e.data);
      compare({name, " hold ovf"},   32'(rsp_ovf), 32'(e.ovf));
      compare({name, " hold id"},    32'(rsp_id), 32'(e.id));
      compare({name, " hold no accept"}, 32'(req0_ready | req1_ready), 32'(0));
      compare({name, " hold count"}, 32'(ovf_count), 32'(exp_cnt));
    end
    rsp_ready = 1'b1;
    #1;
    compare({name, " no accept at handshake"}, 32'(req0_ready | req1_ready), 32'(0));
    tick;
    rsp_ready = 1'b0;
    if (e.ovf && exp_cnt != CNT_MAX) exp_cnt++;
    compare({name, " ovf_count"}, 32'(ovf_count), 32'(exp_cnt));
    compare({name, " idle"}, 32'(busy), 32'(0));
  endtask

  initial begin
    vec_t vecs[11];
    bit   ok;
    int   got;
    int   lat;

    req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_op = '0; req0_unsig = 1'b0;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_op = '0; req1_unsig = 1'b0;
    rsp_ready  = 1'b0;

    vecs[0]  = '{3'b010, 1'b0, 32'd1,         32'd2,         32'd3,         1'b0, 1'b0};
    vecs[1]  = '{3'b000, 1'b0, 32'hF0F0_F0F0, 32'h0FF0_0FF0, 32'h00F0_00F0, 1'b0, 1'b0};
    vecs[2]  = '{3'b001, 1'b0, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 1'b0, 1'b0};
    vecs[3]  = '{3'b100, 1'b0, 32'd5,         32'd7,         32'hFFFF_FFFE, 1'b0, 1'b0};
    vecs[4]  = '{3'b100, 1'b0, 32'h8000_0000, 32'd1,         32'h7FFF_FFFF, 1'b1, 1'b0};
    vecs[5]  = '{3'b101, 1'b0, 32'hAAAA_AAAA, 32'hFFFF_0000, 32'h5555_AAAA, 1'b0, 1'b0};
    vecs[6]  = '{3'b110, 1'b0, 32'hFFFF_FFFF, 32'd1,         32'd1,         1'b0, 1'b0};
    vecs[7]  = '{3'b110, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b0, 1'b0};
    vecs[8]  = '{3'b010, 1'b1, 32'hFFFF_FFFF, 32'd1,         32'd0,         1'b1, 1'b0};
    vecs[9]  = '{3'b011, 1'b0, 32'd5,         32'd6,         32'd0,         1'b0, 1'b1};
`ifdef ALU_ARB_MUL_EN
    vecs[10] = '{3'b111, 1'b0, 32'hFFFF_FFFD, 32'd4,         32'hFFFF_FFF4, 1'b0, 1'b0};
`else
    vecs[10] = '{3'b111, 1'b0, 32'hFFFF_FFFD, 32'd4,         32'd0,         1'b0, 1'b1};
`endif

    // Reset state, with a request already pending.
    req0_valid = 1'b1;
    repeat (2) tick;
    #1;
    compare("reset rsp_valid", 32'(rsp_valid), 32'(0));
    compare("reset busy", 32'(busy), 32'(0));
    compare("reset req0_ready", 32'(req0_ready), 32'(0));
    compare("reset ovf_count", 32'(ovf_count), 32'(0));
    compare("reset alu_a", alu_a, 32'(0));
    compare("reset rsp_data", rsp_data, 32'(0));
    compare("reset rsp_err", 32'(rsp_err), 32'(0));
    req0_valid = 1'b0;
    tick;
    rst_n = 1'b1;
    tick;

    // Overflowing add with a stalled consumer and a competing requester.
    applyStimulus(1'b0, 3'b010, 1'b0, 32'h7FFF_FFFF, 32'd1, '{1'b0, 32'h8000_0000, 1'b1, 1'b0}, ok);
    compare("alu_a from operand reg", alu_a, 32'h7FFF_FFFF);
    req1_a = 32'd9; req1_b = 32'd9; req1_op = 3'b010; req1_unsig = 1'b0; req1_valid = 1'b1;
    if (ok) checkOutput("stall", 2, 5);
    #1;
    compare("accept after idle", 32'(req1_ready), 32'(1));
    req1_valid = 1'b0;
    tick;
    compare("dropped request", 32'(busy), 32'(0));

    // Table-driven vectors on requester 0.
    for (int i = 0; i < 11; i++) begin
      lat = vecs[i].err ? 1 : ((vecs[i].op == 3'b111) ? 3 : 2);
      applyStimulus(1'b0, vecs[i].op, vecs[i].unsig, vecs[i].a, vecs[i].b,
                    '{1'b0, vecs[i].data, vecs[i].ovf, vecs[i].err}, ok);
      if (ok) checkOutput($sformatf("vec%0d", i), lat, 0);
    end

    // Reset during EXEC discards the operation.
    applyStimulus(1'b0, 3'b010, 1'b0, 32'd100, 32'd200, '{1'b0, 32'd300, 1'b0, 1'b0}, ok);
    compare("busy in exec", 32'(busy), 32'(1));
    rst_n = 1'b0;
    #1;
    compare("mid reset busy", 32'(busy), 32'(0));
    compare("mid reset rsp_valid", 32'(rsp_valid), 32'(0));
    compare("mid reset alu_a", alu_a, 32'(0));
    compare("mid reset alu_op", 32'(alu_op), 32'(0));
    compare("mid reset ovf_count", 32'(ovf_count), 32'(0));
    sb_q.delete();
    exp_cnt = '0;
    tick;
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick;
      compare("no rsp after reset", 32'(rsp_valid), 32'(0));
    end
    req0_a = 32'd4; req0_b = 32'd5; req0_op = 3'b010; req0_unsig = 1'b0; req0_valid = 1'b1;
    req1_a = 32'd6; req1_b = 32'd7; req1_op = 3'b010; req1_unsig = 1'b0; req1_valid = 1'b1;
    #1;
    compare("post reset grant req0", 32'(req0_ready), 32'(1));
    compare("post reset no req1", 32'(req1_ready), 32'(0));
    sb_q.push_back('{1'b0, 32'd9, 1'b0, 1'b0});
    tick;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    checkOutput("post reset", 2, 0);

    // Round-robin with both requesters continuously re-asserting.
    doReset;
    req0_a = 32'd10; req0_b = 32'd1; req0_op = 3'b010; req0_unsig = 1'b0; req0_valid = 1'b1;
    req1_a = 32'd20; req1_b = 32'd2; req1_op = 3'b010; req1_unsig = 1'b0; req1_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      got = -1;
      for (int i = 0; i < 20 && got < 0; i++) begin
        #1;
        if (req0_ready) got = 0;
        else if (req1_ready) got = 1;
        else tick;
      end
      compare("rr order", 32'(got), 32'(k % 2));
      if (got < 0) break;
      sb_q.push_back('{(k % 2 == 1), (k % 2 == 1) ? 32'd22 : 32'd11, 1'b0, 1'b0});
      tick;
      if (got == 0) req0_valid = 1'b0;
      else req1_valid = 1'b0;
      checkOutput("rr", 2, 0);
      if (got == 0) req0_valid = 1'b1;
      else req1_valid = 1'b1;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;

    // Saturation of the overflow counter.
    doReset;
    for (int n = 0; n < (1 << OVF_CNT_W) + 2; n++) begin
      applyStimulus(1'b0, 3'b010, 1'b0, 32'h7FFF_FFFF, 32'd1, '{1'b0, 32'h8000_0000, 1'b1, 1'b0}, ok);
      if (!ok) break;
      checkOutput("sat", 2, 0);
    end
    compare("ovf_count saturated", 32'(ovf_count), 32'(CNT_MAX));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
